// File: rtl/burst_gate_n.sv
`default_nettype none
// ------------------------------------------------------------------------
//  burst_gate_n : multi-channel hysteretic burst gate for stochastic
//                 bitstreams with dwell guard and saturating switch count
//  Revision     : 1.0
// ------------------------------------------------------------------------
module burst_gate_n #(
   parameter int NCH       = 4,
   parameter int MEMSIZE   = 2,
   parameter int SET_TH    = MEMSIZE + 1,
   parameter int CLR_TH    = 0,
   parameter int MIN_DWELL = 0,
   parameter int CNTW      = 8
) (
   input  logic                CLK,
   input  logic                INIT,
   input  logic                EN,
   input  logic [NCH-1:0]      IN,
   output logic [NCH-1:0]      OUT,
   output logic [NCH-1:0]      TOGGLE,
   output logic [NCH*CNTW-1:0] SWCNT
);

   localparam int CW = $clog2(MEMSIZE + 2);
   localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

   generate
      if (NCH < 1 || MEMSIZE < 1 || CNTW < 1 || MIN_DWELL < 0 || CLR_TH < 0 ||
          SET_TH <= CLR_TH || SET_TH > MEMSIZE + 1) begin : g_bad_params
         $error("burst_gate_n: illegal parameter combination");
      end
   endgenerate

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [MEMSIZE-1:0] r_mem;
      logic               r_mode;
      logic               r_tog;
      logic [CNTW-1:0]    r_cnt;
      logic [MEMSIZE:0]   w_win;
      logic [CW-1:0]      w_pop;
      logic               w_set;
      logic               w_clr;
      logic               w_ok;
      logic               w_sw;

      assign w_win = {r_mem, IN[gi]};

      always_comb begin
         w_pop = '0;
         for (int k = 0; k <= MEMSIZE; k++) begin
            w_pop = w_pop + CW'(w_win[k]);
         end
      end

      // The input bit itself must oppose the mode, so a matching bit never flips it.
      assign w_set = !r_mode &&  IN[gi] && (w_pop >= CW'(SET_TH));
      assign w_clr =  r_mode && !IN[gi] && (w_pop <= CW'(CLR_TH));
      assign w_sw  = (w_set || w_clr) && w_ok;

      if (MIN_DWELL == 0) begin : g_nodwell
         assign w_ok = 1'b1;
      end else begin : g_dwell
         logic [DW-1:0] r_dwell;

         always_ff @(posedge CLK) begin
            if (INIT) begin
               r_dwell <= '0;
            end else if (EN) begin
               if (w_sw) begin
                  r_dwell <= '0;
               end else if (r_dwell != DW'(MIN_DWELL)) begin
                  r_dwell <= r_dwell + DW'(1);
               end
            end
         end

         assign w_ok = (r_dwell == DW'(MIN_DWELL));
      end

      always_ff @(posedge CLK) begin
         if (INIT) begin
            r_mode <= 1'b0;
            r_mem  <= '0;
            r_tog  <= 1'b0;
            r_cnt  <= '0;
         end else if (EN) begin
            r_mem <= w_win[MEMSIZE-1:0];
            r_tog <= w_sw;
            if (w_sw) begin
               r_mode <= ~r_mode;
               if (r_cnt != {CNTW{1'b1}}) begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
         end else begin
            r_tog <= 1'b0;
         end
      end

      assign OUT[gi]                 = r_mode;
      assign TOGGLE[gi]              = r_tog;
      assign SWCNT[gi*CNTW +: CNTW]  = r_cnt;
   end

endmodule
`default_nettype wire

// File: tb/tb_burst_gate_n.sv
`default_nettype none
// ------------------------------------------------------------------------
//  tb_burst_gate_n : directed and scoreboard checks for burst_gate_n
//  Revision        : 1.0
// ------------------------------------------------------------------------
module tb_burst_gate_n;

   logic        clk  = 1'b0;
   logic        init = 1'b0;
   logic        en   = 1'b1;
   logic [3:0]  in_a = '0;
   logic        in_h = 1'b0;
   logic        in_d = 1'b0;
   logic        in_s = 1'b0;

   logic [3:0]  out_a, tg_a;
   logic [31:0] sw_a;
   logic [0:0]  out_h, tg_h, out_d, tg_d, out_s, tg_s;
   logic [7:0]  sw_h, sw_d;
   logic [1:0]  sw_s;

   int n_checks = 0;
   int n_errors = 0;

   logic m_mode[4];
   logic m_h1[4];
   logic m_h2[4];
   logic m_tog[4];
   int   m_cnt[4];

   always #5 clk = ~clk;

   burst_gate_n #(.NCH(4)) u_a (
      .CLK(clk), .INIT(init), .EN(en), .IN(in_a),
      .OUT(out_a), .TOGGLE(tg_a), .SWCNT(sw_a));

   burst_gate_n #(.NCH(1), .MEMSIZE(4), .SET_TH(4), .CLR_TH(1)) u_h (
      .CLK(clk), .INIT(init), .EN(en), .IN(in_h),
      .OUT(out_h), .TOGGLE(tg_h), .SWCNT(sw_h));

   burst_gate_n #(.NCH(1), .MIN_DWELL(3)) u_d (
      .CLK(clk), .INIT(init), .EN(en), .IN(in_d),
      .OUT(out_d), .TOGGLE(tg_d), .SWCNT(sw_d));

   burst_gate_n #(.NCH(1), .CNTW(2)) u_s (
      .CLK(clk), .INIT(init), .EN(en), .IN(in_s),
      .OUT(out_s), .TOGGLE(tg_s), .SWCNT(sw_s));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      init = 1'b1;
      en   = 1'b1;
      tick();
      init = 1'b0;
      in_a = '0; in_h = 1'b0; in_d = 1'b0; in_s = 1'b0;
   endtask

   task automatic test_reset();
      in_a = 4'hF; in_h = 1'b1; in_d = 1'b1; in_s = 1'b1;
      do_reset();
      n_checks++;
      if (out_a !== 4'h0 || tg_a !== 4'h0 || sw_a !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_a out=%h tog=%h sw=%h required 0/0/0", out_a, tg_a, sw_a);
      end
      n_checks++;
      if (out_h !== 1'b0 || tg_h !== 1'b0 || sw_h !== 8'h0) begin
         n_errors++;
         $display("FAIL reset_h out=%b tog=%b sw=%h required 0/0/0", out_h, tg_h, sw_h);
      end
      n_checks++;
      if (out_d !== 1'b0 || tg_d !== 1'b0 || sw_d !== 8'h0) begin
         n_errors++;
         $display("FAIL reset_d out=%b tog=%b sw=%h required 0/0/0", out_d, tg_d, sw_d);
      end
      n_checks++;
      if (out_s !== 1'b0 || tg_s !== 1'b0 || sw_s !== 2'h0) begin
         n_errors++;
         $display("FAIL reset_s out=%b tog=%b sw=%h required 0/0/0", out_s, tg_s, sw_s);
      end
   endtask

   task automatic test_legacy();
      logic ins [10] = '{1,1,1, 0,0,0, 1,0,1,0};
      logic eo  [10] = '{0,0,1, 1,1,0, 0,0,0,0};
      logic et  [10] = '{0,0,1, 0,0,1, 0,0,0,0};
      do_reset();
      for (int k = 0; k < 10; k++) begin
         in_a = {3'b000, ins[k]};
         tick();
         n_checks++;
         if (out_a[0] !== eo[k] || tg_a[0] !== et[k]) begin
            n_errors++;
            $display("FAIL legacy step %0d out=%b tog=%b required %b/%b", k, out_a[0], tg_a[0], eo[k], et[k]);
         end
         if (k == 5) begin
            n_checks++;
            if (sw_a[7:0] !== 8'd2) begin
               n_errors++;
               $display("FAIL legacy_swcnt got %0d required 2", sw_a[7:0]);
            end
         end
      end
   endtask

   task automatic test_hysteresis();
      logic ins [9] = '{1,1,0,1,1, 0,0,0,0};
      logic eo  [9] = '{0,0,0,0,1, 1,1,1,0};
      logic et  [9] = '{0,0,0,0,1, 0,0,0,1};
      do_reset();
      for (int k = 0; k < 9; k++) begin
         in_h = ins[k];
         tick();
         n_checks++;
         if (out_h[0] !== eo[k] || tg_h[0] !== et[k]) begin
            n_errors++;
            $display("FAIL hyst step %0d out=%b tog=%b required %b/%b", k, out_h[0], tg_h[0], eo[k], et[k]);
         end
      end
      n_checks++;
      if (sw_h !== 8'd2) begin
         n_errors++;
         $display("FAIL hyst_swcnt got %0d required 2", sw_h);
      end
   endtask

   task automatic test_dwell();
      logic ins [8] = '{1,1,1,1, 0,0,0,0};
      logic eo  [8] = '{0,0,0,1, 1,1,1,0};
      logic et  [8] = '{0,0,0,1, 0,0,0,1};
      do_reset();
      for (int k = 0; k < 8; k++) begin
         in_d = ins[k];
         tick();
         n_checks++;
         if (out_d[0] !== eo[k] || tg_d[0] !== et[k]) begin
            n_errors++;
            $display("FAIL dwell step %0d out=%b tog=%b required %b/%b", k, out_d[0], tg_d[0], eo[k], et[k]);
         end
      end
   endtask

   task automatic test_enable();
      do_reset();
      in_a = 4'h1; tick(); tick();
      // Zeros during the freeze must not enter the history.
      en = 1'b0; in_a = 4'h0; tick(); tick();
      n_checks++;
      if (out_a[0] !== 1'b0 || tg_a[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL enable_frozen out=%b tog=%b required 0/0", out_a[0], tg_a[0]);
      end
      en = 1'b1; in_a = 4'h1; tick();
      n_checks++;
      if (out_a[0] !== 1'b1 || tg_a[0] !== 1'b1 || sw_a[7:0] !== 8'd1) begin
         n_errors++;
         $display("FAIL enable_resume out=%b tog=%b sw=%0d required 1/1/1", out_a[0], tg_a[0], sw_a[7:0]);
      end
      en = 1'b0; in_a = 4'h0; tick();
      n_checks++;
      if (out_a[0] !== 1'b1 || tg_a[0] !== 1'b0 || sw_a[7:0] !== 8'd1) begin
         n_errors++;
         $display("FAIL enable_toggle_clear out=%b tog=%b sw=%0d required 1/0/1", out_a[0], tg_a[0], sw_a[7:0]);
      end
      en = 1'b1;
   endtask

   task automatic test_init_abort();
      do_reset();
      in_a = 4'h1; tick(); tick(); tick();
      in_a = 4'h0; tick(); tick();
      init = 1'b1; tick();
      n_checks++;
      if (out_a !== 4'h0 || tg_a !== 4'h0 || sw_a !== 32'h0) begin
         n_errors++;
         $display("FAIL init_abort_clear out=%h tog=%h sw=%h required 0/0/0", out_a, tg_a, sw_a);
      end
      init = 1'b0; tick();
      n_checks++;
      if (out_a[0] !== 1'b0 || tg_a[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL init_abort_noswitch out=%b tog=%b required 0/0", out_a[0], tg_a[0]);
      end
      in_a = 4'h1; tick(); tick();
      init = 1'b1; tick();
      init = 1'b0; tick(); tick();
      n_checks++;
      if (out_a[0] !== 1'b0 || tg_a[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL init_window_flush out=%b tog=%b required 0/0", out_a[0], tg_a[0]);
      end
      tick();
      n_checks++;
      if (out_a[0] !== 1'b1 || tg_a[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL init_refill out=%b tog=%b required 1/1", out_a[0], tg_a[0]);
      end
   endtask

   task automatic test_saturation();
      int pulses = 0;
      int want;
      do_reset();
      for (int t = 0; t < 5; t++) begin
         in_s = (t % 2 == 0);
         for (int j = 0; j < 3; j++) begin
            tick();
            if (tg_s[0] === 1'b1) pulses++;
         end
         want = (t + 1 > 3) ? 3 : t + 1;
         n_checks++;
         if (out_s[0] !== in_s || tg_s[0] !== 1'b1 || sw_s !== want[1:0]) begin
            n_errors++;
            $display("FAIL sat switch %0d out=%b tog=%b sw=%0d required %b/1/%0d", t, out_s[0], tg_s[0], sw_s, in_s, want);
         end
      end
      n_checks++;
      if (pulses != 5) begin
         n_errors++;
         $display("FAIL sat_pulses got %0d required 5", pulses);
      end
   endtask

   task automatic model_step(input logic ini, input logic e, input logic [3:0] x);
      logic sw;
      for (int c = 0; c < 4; c++) begin
         if (ini) begin
            m_mode[c] = 1'b0; m_h1[c] = 1'b0; m_h2[c] = 1'b0; m_tog[c] = 1'b0; m_cnt[c] = 0;
         end else if (!e) begin
            m_tog[c] = 1'b0;
         end else begin
            sw = (!m_mode[c] &&  x[c] &&  m_h1[c] &&  m_h2[c]) ||
                 ( m_mode[c] && !x[c] && !m_h1[c] && !m_h2[c]);
            if (sw) begin
               m_mode[c] = ~m_mode[c];
               if (m_cnt[c] < 255) m_cnt[c]++;
            end
            m_tog[c] = sw;
            m_h2[c]  = m_h1[c];
            m_h1[c]  = x[c];
         end
      end
   endtask

   task automatic sb_cycle(input logic ini, input logic e, input logic [3:0] x);
      logic [3:0]  eo, et;
      logic [31:0] es;
      init = ini; en = e; in_a = x;
      model_step(ini, e, x);
      tick();
      for (int c = 0; c < 4; c++) begin
         eo[c] = m_mode[c];
         et[c] = m_tog[c];
         es[c*8 +: 8] = m_cnt[c][7:0];
      end
      n_checks++;
      if (out_a !== eo) begin
         n_errors++;
         $display("FAIL sb_out got %h required %h", out_a, eo);
      end
      n_checks++;
      if (tg_a !== et) begin
         n_errors++;
         $display("FAIL sb_toggle got %h required %h", tg_a, et);
      end
      n_checks++;
      if (sw_a !== es) begin
         n_errors++;
         $display("FAIL sb_swcnt got %h required %h", sw_a, es);
      end
   endtask

   task automatic test_multichannel();
      logic [3:0] x;
      model_step(1'b1, 1'b1, 4'h0);
      do_reset();
      // Channels 0 and 1 rise together; channel 2 alternates; channel 3 idles.
      sb_cycle(1'b0, 1'b1, 4'b0111);
      sb_cycle(1'b0, 1'b1, 4'b0011);
      sb_cycle(1'b0, 1'b1, 4'b0111);
      n_checks++;
      if (tg_a !== 4'b0011 || out_a !== 4'b0011) begin
         n_errors++;
         $display("FAIL mc_simultaneous tog=%b out=%b required 0011/0011", tg_a, out_a);
      end
      x = 4'b0111;
      for (int n = 0; n < 10000; n++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 3) == 0) x[c] = ~x[c];
         end
         sb_cycle($urandom_range(0, 999) == 0, $urandom_range(0, 9) != 0, x);
      end
      init = 1'b0; en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_legacy();
      test_hysteresis();
      test_dwell();
      test_enable();
      test_init_abort();
      test_saturation();
      test_multichannel();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/burst_gate_n.md
# burst_gate_n

Multi-channel, parametrised burst gate for stochastic bitstreams. Each channel tracks a hysteretic output mode from a sliding window of recent input bits. Each channel can also require a minimum dwell time between switches, and reports switch events and a saturating switch count. It sits between stochastic neuron outputs and downstream accumulators and replaces the fixed two-bit, single-channel burst gate in new network builds.

## Interface

- NCH, 4: number of independent channels.
- MEMSIZE, 2: history depth per channel, in previous samples. Must be ≥1.
- SET_TH, MEMSIZE+1: minimum number of ones in the window needed to switch mode 0→1. Range CLR_TH+1..MEMSIZE+1.
- CLR_TH, 0: maximum number of ones in the window allowed to switch mode 1→0. Range 0..SET_TH-1.
- MIN_DWELL, 0: number of enabled cycles a mode must be held before a switch is allowed. 0 disables the check.
- CNTW, 8: width of each switch counter.
- An illegal parameter combination must stop elaboration with an error.

Ports:

- CLK  in  1  system clock; all state updates on the rising edge.
- INIT  in  1  synchronous, active-high reset.
- EN  in  1  sample enable; when low, all state holds.
- IN  in  NCH  input bit per channel; bit i belongs to channel i.
- OUT  out  NCH  registered gated output per channel.
- TOGGLE  out  NCH  one-cycle pulse on the cycle after a channel switches mode.
- SWCNT  out  NCH*CNTW  saturating switch count per channel; channel i occupies bits [i*CNTW +: CNTW].

## Operation

Per-channel state:

- MODE, 1 bit.
- MEM, MEMSIZE bits; MEM[0] is the newest sample.
- DWELL, wide enough to hold MIN_DWELL; saturates at MIN_DWELL.
- CNT, CNTW bits.

Window and count:

- The window W is {MEM, IN[i]}, MEMSIZE+1 bits wide.
- c is the popcount of W. It is combinational and CLOG2(MEMSIZE+2) bits wide.
- The switch is permitted (ok) when DWELL ≥ MIN_DWELL. With MIN_DWELL=0, ok is always 1.

On each rising edge with INIT=0 and EN=1:

- MODE=0, IN=1, c ≥ SET_TH, ok=1: switch to MODE 1.
- MODE=1, IN=0, c ≤ CLR_TH, ok=1: switch to MODE 0.
- Otherwise MODE holds. An input that matches MODE never causes a switch.
- MEM shifts: MEM ← {MEM[MEMSIZE-2:0], IN[i]}. For MEMSIZE=1, MEM ← IN[i].
- OUT[i] ← the new MODE value.
- On a switch:
  - TOGGLE[i] ← 1.
  - DWELL ← 0.
  - CNT ← CNT+1, saturating at 2^CNTW-1.
- With no switch:
  - TOGGLE[i] ← 0.
  - DWELL ← min(DWELL+1, MIN_DWELL).

Other cases:

- EN=0: MODE, MEM, DWELL, CNT and OUT all hold. TOGGLE ← 0.
- INIT=1 (regardless of EN): MODE, MEM, DWELL, CNT, OUT and TOGGLE all clear to 0.
- Channels are fully independent. Simultaneous switches on several channels are each counted.
- Default parameters with MEMSIZE=2 reproduce the legacy behaviour: three consecutive equal bits opposite to the current mode flip the mode.

## Timing

- Reset values: OUT=0, TOGGLE=0, SWCNT=0, MODE=0, MEM=0, DWELL=0.
- INIT takes effect at the edge where it is sampled. It aborts any partially filled window.
- Latency is one cycle from IN to OUT. OUT reflects the mode decided from the input sampled at the same edge.
- TOGGLE is asserted for exactly one cycle, in the same cycle OUT changes.
- Dwell after INIT: DWELL starts at 0, so when MIN_DWELL>0 the first switch is blocked until MIN_DWELL enabled cycles have elapsed.
- Disabled cycles (EN=0) do not advance DWELL.
- When c meets a threshold but ok=0, no switch occurs. The switch happens on the first later enabled cycle where both conditions hold on the then-current window.
- CNT at all ones stays at all ones. TOGGLE still pulses on a switch at saturation.
- No combinational path from IN or EN to any output.

## Test plan

- Legacy equivalence (defaults, NCH=1, MEMSIZE=2): after INIT, IN=1,1,1 → OUT=0,0,1. TOGGLE pulses once, with the third sample. Then IN=0,0,0 → OUT=1,1,0 and SWCNT=2. IN=1,0,1,0 alternating → OUT never changes.
- Hysteresis thresholds (MEMSIZE=4, SET_TH=4, CLR_TH=1, mode 0, history 0000): IN=1,1,0,1,1 → switch at the 5th sample (c=4). Then IN=0,0,0 → switch when c≤1.
- Dwell (MIN_DWELL=3, defaults otherwise): directly after INIT, IN=1,1,1 → no switch at cycle 3. Switch at cycle 4 with IN=1. An immediate run of three 0s is then blocked until DWELL reaches 3.
- Enable and reset: toggle EN low mid-burst → state frozen, TOGGLE=0, and the burst resumes on re-enable. Assert INIT one cycle before a pending switch → all outputs 0 and the switch never occurs.
- Saturation (CNTW=2): force 5 switches → SWCNT=3 while TOGGLE still pulses 5 times.
- Multi-channel (NCH=4): drive different patterns on each channel, including two channels switching on the same edge → each channel matches a per-channel scoreboard model. Random stimulus for 10k cycles.
